// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: every handshake and bus signal of mem_arbiter in one bundle.
//   slave  : the arbiter's view. It receives the IFU/LSU requests and the
//            memory responses, and it drives the grants, the responses and
//            the memory request.
//   master : the environment's view (requesters plus memory model), i.e. the
//            mirror image of slave.
// Signal groups:
//   ifu_* : read-only fetch requester (req/resp valid-ready, addr, rdata)
//   lsu_* : load/store requester (req/resp valid-ready, addr, wen, wdata,
//           wmask, rdata)
//   mem_* : single downstream memory port
//   busy_o: arbiter is not idle
interface mem_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    ifu_req_valid_i;
  logic                    ifu_req_ready_o;
  logic [ADDR_WIDTH-1:0]   ifu_addr_i;
  logic                    ifu_resp_valid_o;
  logic                    ifu_resp_ready_i;
  logic [DATA_WIDTH-1:0]   ifu_rdata_o;

  logic                    lsu_req_valid_i;
  logic                    lsu_req_ready_o;
  logic [ADDR_WIDTH-1:0]   lsu_addr_i;
  logic                    lsu_wen_i;
  logic [DATA_WIDTH-1:0]   lsu_wdata_i;
  logic [DATA_WIDTH/8-1:0] lsu_wmask_i;
  logic                    lsu_resp_valid_o;
  logic                    lsu_resp_ready_i;
  logic [DATA_WIDTH-1:0]   lsu_rdata_o;

  logic                    mem_req_valid_o;
  logic                    mem_req_ready_i;
  logic [ADDR_WIDTH-1:0]   mem_addr_o;
  logic                    mem_wen_o;
  logic [DATA_WIDTH-1:0]   mem_wdata_o;
  logic [DATA_WIDTH/8-1:0] mem_wmask_o;
  logic                    mem_resp_valid_i;
  logic                    mem_resp_ready_o;
  logic [DATA_WIDTH-1:0]   mem_rdata_i;

  logic                    busy_o;

  modport slave (
    input  ifu_req_valid_i, ifu_addr_i, ifu_resp_ready_i,
           lsu_req_valid_i, lsu_addr_i, lsu_wen_i, lsu_wdata_i, lsu_wmask_i,
           lsu_resp_ready_i, mem_req_ready_i, mem_resp_valid_i, mem_rdata_i,
    output ifu_req_ready_o, ifu_resp_valid_o, ifu_rdata_o,
           lsu_req_ready_o, lsu_resp_valid_o, lsu_rdata_o,
           mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o,
           mem_resp_ready_o, busy_o
  );

  modport master (
    output ifu_req_valid_i, ifu_addr_i, ifu_resp_ready_i,
           lsu_req_valid_i, lsu_addr_i, lsu_wen_i, lsu_wdata_i, lsu_wmask_i,
           lsu_resp_ready_i, mem_req_ready_i, mem_resp_valid_i, mem_rdata_i,
    input  ifu_req_ready_o, ifu_resp_valid_o, ifu_rdata_o,
           lsu_req_ready_o, lsu_resp_valid_o, lsu_rdata_o,
           mem_req_valid_o, mem_addr_o, mem_wen_o, mem_wdata_o, mem_wmask_o,
           mem_resp_ready_o, busy_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between the IFU (read-only) and the
// LSU (loads and stores), with at most one transaction in flight.
// Flow: IDLE (grant + accept) -> ISSUE (memory request) -> WAIT (memory
// response) -> RESP (response to the owner) -> IDLE.
// Ports:
//   clk_i : clock, rising edge
//   rst_i : asynchronous, active-high reset
//   bus   : mem_arbiter_if.slave, which carries the IFU, LSU and memory
//           handshakes plus busy_o
// Build option:
//   ARB_RR_EN : defined    -> round-robin between IFU and LSU under contention
//               undefined  -> fixed priority, LSU over IFU
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mem_arbiter_if.slave   bus
);
  localparam int MASK_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t                state, state_nxt;
  logic                  owner_lsu;   // 0 = IFU owns the transaction, 1 = LSU
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  wen_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [MASK_WIDTH-1:0] wmask_q;
  logic [DATA_WIDTH-1:0] data_q;

  logic gnt_ifu, gnt_lsu;
  logic accept;

`ifdef ARB_RR_EN
  // last_lsu records who won the previous accept. Under contention the other
  // requester wins. It resets to LSU so that the first contended grant goes
  // to IFU.
  logic last_lsu;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)       last_lsu <= 1'b1;
    else if (accept) last_lsu <= gnt_lsu;
  end

  assign gnt_lsu = bus.lsu_req_valid_i & (~bus.ifu_req_valid_i | ~last_lsu);
`else
  assign gnt_lsu = bus.lsu_req_valid_i;
`endif
  assign gnt_ifu = bus.ifu_req_valid_i & ~gnt_lsu;

  // A grant implies its valid is high, so a grant in IDLE is a handshake.
  assign accept = (state == IDLE) & (gnt_ifu | gnt_lsu);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt            = state;
    bus.ifu_req_ready_o  = 1'b0;
    bus.lsu_req_ready_o  = 1'b0;
    bus.mem_req_valid_o  = 1'b0;
    bus.mem_resp_ready_o = 1'b0;
    bus.ifu_resp_valid_o = 1'b0;
    bus.lsu_resp_valid_o = 1'b0;
    bus.busy_o           = 1'b1;
    case (state)
      IDLE: begin
        bus.busy_o          = 1'b0;
        bus.ifu_req_ready_o = gnt_ifu;
        bus.lsu_req_ready_o = gnt_lsu;
        if (accept) state_nxt = ISSUE;
      end
      ISSUE: begin
        bus.mem_req_valid_o = 1'b1;
        if (bus.mem_req_ready_i) state_nxt = WAIT;
      end
      WAIT: begin
        bus.mem_resp_ready_o = 1'b1;
        if (bus.mem_resp_valid_i) state_nxt = RESP;
      end
      RESP: begin
        bus.ifu_resp_valid_o = ~owner_lsu;
        bus.lsu_resp_valid_o = owner_lsu;
        if (owner_lsu ? bus.lsu_resp_ready_i : bus.ifu_resp_ready_i)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are latched once at accept. They then stay stable for the
  // whole transaction. IFU requests always latch a read with an empty mask.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      owner_lsu <= 1'b0;
      addr_q    <= '0;
      wen_q     <= 1'b0;
      wdata_q   <= '0;
      wmask_q   <= '0;
      data_q    <= '0;
    end else begin
      if (accept) begin
        owner_lsu <= gnt_lsu;
        addr_q    <= gnt_lsu ? bus.lsu_addr_i : bus.ifu_addr_i;
        wen_q     <= gnt_lsu & bus.lsu_wen_i;
        wdata_q   <= gnt_lsu ? bus.lsu_wdata_i : '0;
        wmask_q   <= gnt_lsu ? bus.lsu_wmask_i : '0;
      end
      if (state == WAIT && bus.mem_resp_valid_i) data_q <= bus.mem_rdata_i;
    end
  end

  assign bus.mem_addr_o  = addr_q;
  assign bus.mem_wen_o   = wen_q;
  assign bus.mem_wdata_o = wdata_q;
  assign bus.mem_wmask_o = wmask_q;
  assign bus.ifu_rdata_o = data_q;
  assign bus.lsu_rdata_o = data_q;
endmodule
